// File: rtl/pif_bus_pkg.sv
// Shared definitions for the PIF bus fabric: error codes, FSM encoding and the
// PIF memory map used when the fabric is instantiated next to the 6502 core.
package pif_bus_pkg;

  localparam int PIF_NUM_SLAVES = 8;
  localparam int PIF_ADDR_W     = 16;
  localparam int PIF_DATA_W     = 8;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_UNMAPPED = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT     = 2'd1,
    ST_ERR_RESP = 2'd2
  } pif_state_e;

  localparam int IDX_RAM   = 0;
  localparam int IDX_PRAM  = 1;
  localparam int IDX_PROM  = 2;
  localparam int IDX_CRC   = 3;
  localparam int IDX_CTRL  = 4;
  localparam int IDX_EEP   = 5;
  localparam int IDX_N64IF = 6;
  localparam int IDX_ROMX  = 7;

  localparam logic [15:0] RAM_BASE   = 16'h0000;
  localparam logic [15:0] RAM_MASK   = 16'hF000;
  localparam logic [15:0] PRAM_BASE  = 16'h1000;
  localparam logic [15:0] PRAM_MASK  = 16'hF000;
  localparam logic [15:0] PROM_BASE  = 16'h2000;
  localparam logic [15:0] PROM_MASK  = 16'hF000;
  localparam logic [15:0] CRC_BASE   = 16'h3280;
  localparam logic [15:0] CRC_MASK   = 16'hFFE0;
  localparam logic [15:0] CTRL_BASE  = 16'h32A0;
  localparam logic [15:0] CTRL_MASK  = 16'hFFF0;
  localparam logic [15:0] EEP_BASE   = 16'h32B0;
  localparam logic [15:0] EEP_MASK   = 16'hFFF0;
  localparam logic [15:0] N64IF_BASE = 16'h32C0;
  localparam logic [15:0] N64IF_MASK = 16'hFFF0;
  // Slave 7 is a catch-all ROM window: an all-zero mask matches every address.
  localparam logic [15:0] ROMX_BASE  = 16'h0000;
  localparam logic [15:0] ROMX_MASK  = 16'h0000;

  localparam logic [PIF_NUM_SLAVES*PIF_ADDR_W-1:0] PIF_SLAVE_BASE = {
    ROMX_BASE, N64IF_BASE, EEP_BASE, CTRL_BASE,
    CRC_BASE, PROM_BASE, PRAM_BASE, RAM_BASE
  };

  localparam logic [PIF_NUM_SLAVES*PIF_ADDR_W-1:0] PIF_SLAVE_MASK = {
    ROMX_MASK, N64IF_MASK, EEP_MASK, CTRL_MASK,
    CRC_MASK, PROM_MASK, PRAM_MASK, RAM_MASK
  };

endpackage

// File: rtl/pif_bus_decode.sv
// Combinational address decoder: lowest matching region index wins, otherwise
// the default slave, or an unmapped flag when there is no default.
module pif_bus_decode
  import pif_bus_pkg::*;
#(
  parameter int                            NUM_SLAVES    = 8,
  parameter int                            ADDR_W        = 16,
  parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLAVE_BASE    = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLAVE_MASK    = '0,
  parameter int                            DEFAULT_SLAVE = NUM_SLAVES
) (
  input  logic [ADDR_W-1:0]                   addr_i,
  output logic [$clog2(NUM_SLAVES+1)-1:0]     idx_o,
  output logic                                unmapped_o
);

  localparam int IDX_W = $clog2(NUM_SLAVES + 1);

  logic hit;

  // Walk downward so the lowest matching index is the last one written.
  always_comb begin
    hit   = 1'b0;
    idx_o = IDX_W'(DEFAULT_SLAVE);
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr_i & SLAVE_MASK[i*ADDR_W +: ADDR_W]) ==
          (SLAVE_BASE[i*ADDR_W +: ADDR_W] & SLAVE_MASK[i*ADDR_W +: ADDR_W])) begin
        hit   = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
  end

  assign unmapped_o = !hit && (DEFAULT_SLAVE >= NUM_SLAVES);

endmodule

// File: rtl/pif_bus_fabric.sv
// Single-outstanding bus fabric between the PIF 6502 core and its slaves, with
// wait-state timeout, unmapped-address response and sticky error capture.
module pif_bus_fabric
  import pif_bus_pkg::*;
#(
  parameter int                            NUM_SLAVES    = 8,
  parameter int                            ADDR_W        = 16,
  parameter int                            DATA_W        = 8,
  parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLAVE_BASE    = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLAVE_MASK    = '0,
  parameter int                            DEFAULT_SLAVE = NUM_SLAVES,
  parameter int                            TIMEOUT       = 15,
  parameter logic [DATA_W-1:0]             ERR_DATA      = 8'hFF
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          cpu_req_i,
  input  logic [ADDR_W-1:0]             cpu_addr_i,
  input  logic                          cpu_we_i,
  input  logic [DATA_W-1:0]             cpu_wdata_i,
  output logic [DATA_W-1:0]             cpu_rdata_o,
  output logic                          cpu_ready_o,
  output logic [NUM_SLAVES-1:0]         slave_sel_o,
  output logic [NUM_SLAVES-1:0]         slave_wr_o,
  output logic [ADDR_W-1:0]             slave_addr_o,
  output logic [DATA_W-1:0]             slave_wdata_o,
  input  logic [NUM_SLAVES*DATA_W-1:0]  slave_rdata_i,
  input  logic [NUM_SLAVES-1:0]         slave_valid_i,
  input  logic                          err_clear_i,
  output logic                          bus_err_o,
  output logic [1:0]                    err_cause_o,
  output logic [ADDR_W-1:0]             err_addr_o
);

  localparam int IDX_W = $clog2(NUM_SLAVES + 1);
  localparam int TMR_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = '1;
  localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;

  localparam logic [1:0] S_IDLE     = 2'(ST_IDLE);
  localparam logic [1:0] S_WAIT     = 2'(ST_WAIT);
  localparam logic [1:0] S_ERR_RESP = 2'(ST_ERR_RESP);

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              bus_err_q;
  logic [1:0]        err_cause_q;
  logic [ADDR_W-1:0] err_addr_q;

  logic [IDX_W-1:0]  dec_idx;
  logic              dec_unmapped;
  logic              sel_valid;
  logic [DATA_W-1:0] sel_rdata;
  logic              issue;
  logic              err_ev;
  logic [1:0]        err_cause_ev;
  logic [ADDR_W-1:0] err_addr_ev;

  pif_bus_decode #(
    .NUM_SLAVES    (NUM_SLAVES),
    .ADDR_W        (ADDR_W),
    .SLAVE_BASE    (SLAVE_BASE),
    .SLAVE_MASK    (SLAVE_MASK),
    .DEFAULT_SLAVE (DEFAULT_SLAVE)
  ) u_decode (
    .addr_i     (cpu_addr_i),
    .idx_o      (dec_idx),
    .unmapped_o (dec_unmapped)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_valid = slave_valid_i[i];
        sel_rdata = slave_rdata_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign issue = (state_q == S_IDLE) && cpu_req_i && !reset_i;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    tmr_d   = tmr_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req_i) begin
          idx_d   = dec_idx;
          addr_d  = cpu_addr_i;
          tmr_d   = '0;
          state_d = dec_unmapped ? S_ERR_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (tmr_q != TMR_MAX) tmr_d = tmr_q + 1'b1;
        if (sel_valid) begin
          state_d = S_IDLE;
        end else if ((TIMEOUT != 0) && (tmr_q == TMR_LAST)) begin
          state_d = S_ERR_RESP;
        end
      end
      S_ERR_RESP: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    slave_sel_o = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      slave_sel_o[i] = issue && !dec_unmapped && (dec_idx == IDX_W'(i));
    end
  end

  assign slave_wr_o    = slave_sel_o & {NUM_SLAVES{cpu_we_i}};
  assign slave_addr_o  = cpu_addr_i;
  assign slave_wdata_o = cpu_wdata_i;

  always_comb begin
    cpu_ready_o = 1'b0;
    cpu_rdata_o = '0;
    if (!reset_i) begin
      if (state_q == S_WAIT) begin
        cpu_ready_o = sel_valid;
        cpu_rdata_o = sel_rdata;
      end else if (state_q == S_ERR_RESP) begin
        cpu_ready_o = 1'b1;
        cpu_rdata_o = ERR_DATA;
      end
    end
  end

  // Errors are captured on the edge into ERR_RESP; IDLE-origin means unmapped.
  assign err_ev       = (state_d == S_ERR_RESP) && (state_q != S_ERR_RESP);
  assign err_cause_ev = (state_q == S_IDLE) ? ERR_UNMAPPED : ERR_TIMEOUT;
  assign err_addr_ev  = (state_q == S_IDLE) ? cpu_addr_i : addr_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      tmr_q   <= tmr_d;
    end
  end

  // A clear coinciding with a new error lets the new error through.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bus_err_q   <= 1'b0;
      err_cause_q <= ERR_NONE;
      err_addr_q  <= '0;
    end else if (err_ev && (!bus_err_q || err_clear_i)) begin
      bus_err_q   <= 1'b1;
      err_cause_q <= err_cause_ev;
      err_addr_q  <= err_addr_ev;
    end else if (err_clear_i) begin
      bus_err_q   <= 1'b0;
      err_cause_q <= ERR_NONE;
      err_addr_q  <= '0;
    end
  end

  assign bus_err_o   = bus_err_q;
  assign err_cause_o = err_cause_q;
  assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_pif_bus_fabric.sv
// Directed bench: fabric A uses the PIF map with a catch-all ROM; fabric B has
// no catch-all and no default slave so unmapped accesses can be exercised.
module tb_pif_bus_fabric;
  import pif_bus_pkg::*;

  localparam logic [127:0] B_BASE = {16'h3FF0, PIF_SLAVE_BASE[111:0]};
  localparam logic [127:0] B_MASK = {16'hFFFF, PIF_SLAVE_MASK[111:0]};

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, req_b, we, err_clear;
  logic [15:0] addr, dec_addr;
  logic [7:0]  wdata, svld;
  logic [63:0] srd;

  logic [7:0]  rdata_a, rdata_b, sel_a, sel_b, wr_a, wr_b, swd_a, swd_b;
  logic        ready_a, ready_b, berr_a, berr_b;
  logic [1:0]  cause_a, cause_b;
  logic [15:0] saddr_a, saddr_b, eaddr_a, eaddr_b;
  logic [3:0]  didx_a, didx_b;
  logic        dun_a, dun_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] dtab_addr [9] = '{16'h0123, 16'h1FFF, 16'h2ABC, 16'h329F, 16'h32A0,
                                 16'h32B5, 16'h32CF, 16'h32D0, 16'hF000};
  logic [3:0]  dtab_idx  [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd7};

  always #5 clk = ~clk;

  pif_bus_fabric #(
    .NUM_SLAVES(8), .ADDR_W(16), .DATA_W(8),
    .SLAVE_BASE(PIF_SLAVE_BASE), .SLAVE_MASK(PIF_SLAVE_MASK),
    .DEFAULT_SLAVE(8), .TIMEOUT(4), .ERR_DATA(8'hFF)
  ) u_dut_a (
    .clk_i(clk), .reset_i(reset), .cpu_req_i(req_a), .cpu_addr_i(addr),
    .cpu_we_i(we), .cpu_wdata_i(wdata), .cpu_rdata_o(rdata_a), .cpu_ready_o(ready_a),
    .slave_sel_o(sel_a), .slave_wr_o(wr_a), .slave_addr_o(saddr_a),
    .slave_wdata_o(swd_a), .slave_rdata_i(srd), .slave_valid_i(svld),
    .err_clear_i(err_clear), .bus_err_o(berr_a), .err_cause_o(cause_a),
    .err_addr_o(eaddr_a)
  );

  pif_bus_fabric #(
    .NUM_SLAVES(8), .ADDR_W(16), .DATA_W(8),
    .SLAVE_BASE(B_BASE), .SLAVE_MASK(B_MASK),
    .DEFAULT_SLAVE(8), .TIMEOUT(4), .ERR_DATA(8'hFF)
  ) u_dut_b (
    .clk_i(clk), .reset_i(reset), .cpu_req_i(req_b), .cpu_addr_i(addr),
    .cpu_we_i(we), .cpu_wdata_i(wdata), .cpu_rdata_o(rdata_b), .cpu_ready_o(ready_b),
    .slave_sel_o(sel_b), .slave_wr_o(wr_b), .slave_addr_o(saddr_b),
    .slave_wdata_o(swd_b), .slave_rdata_i(srd), .slave_valid_i(svld),
    .err_clear_i(err_clear), .bus_err_o(berr_b), .err_cause_o(cause_b),
    .err_addr_o(eaddr_b)
  );

  pif_bus_decode #(
    .NUM_SLAVES(8), .ADDR_W(16), .SLAVE_BASE(PIF_SLAVE_BASE),
    .SLAVE_MASK(PIF_SLAVE_MASK), .DEFAULT_SLAVE(8)
  ) u_dec_a (.addr_i(dec_addr), .idx_o(didx_a), .unmapped_o(dun_a));

  pif_bus_decode #(
    .NUM_SLAVES(8), .ADDR_W(16), .SLAVE_BASE(B_BASE),
    .SLAVE_MASK(B_MASK), .DEFAULT_SLAVE(8)
  ) u_dec_b (.addr_i(dec_addr), .idx_o(didx_b), .unmapped_o(dun_b));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; req_a = 1'b0; req_b = 1'b0; we = 1'b0; err_clear = 1'b0;
    addr = '0; dec_addr = '0; wdata = '0; svld = '0;
    srd = {8'h77, 8'h66, 8'h55, 8'h44, 8'hC3, 8'h22, 8'h11, 8'h5A};

    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_ready_a", ready_a, 0);
    check_eq("rst_rdata_a", rdata_a, 0);
    check_eq("rst_sel_a",   sel_a,   0);
    check_eq("rst_berr_a",  berr_a,  0);
    check_eq("rst_cause_b", cause_b, 0);
    check_eq("rst_eaddr_b", eaddr_b, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      dec_addr = dtab_addr[i];
      #1 check_eq("dec_idx_a", didx_a, dtab_idx[i]);
      check_eq("dec_unmapped_a", dun_a, 0);
    end
    dec_addr = 16'h4000;
    #1 check_eq("dec_unmapped_b", dun_b, 1);
    dec_addr = 16'h3291;
    #1 check_eq("dec_overlap_b", didx_b, 3);

    // Read RAM 0x0123
    @(negedge clk);
    req_a = 1'b1; addr = 16'h0123; we = 1'b0;
    #1 check_eq("rd_sel", sel_a, 8'h01);
    check_eq("rd_wr", wr_a, 8'h00);
    check_eq("rd_ready_issue", ready_a, 0);
    check_eq("rd_saddr", saddr_a, 16'h0123);
    @(negedge clk);
    req_a = 1'b0; svld = 8'h01;
    #1 check_eq("rd_ready", ready_a, 1);
    check_eq("rd_rdata", rdata_a, 8'h5A);
    check_eq("rd_sel_wait", sel_a, 8'h00);
    @(negedge clk);
    svld = 8'h00;
    #1 check_eq("rd_idle_ready", ready_a, 0);
    check_eq("rd_idle_rdata", rdata_a, 8'h00);

    // Write CTRL 0x32A4; a stray valid from slave 0 must be ignored
    req_a = 1'b1; addr = 16'h32A4; we = 1'b1; wdata = 8'h3C;
    #1 check_eq("wr_sel", sel_a, 8'h10);
    check_eq("wr_wr", wr_a, 8'h10);
    check_eq("wr_wdata", swd_a, 8'h3C);
    @(negedge clk);
    req_a = 1'b0; svld = 8'h01;
    #1 check_eq("wr_foreign_valid", ready_a, 0);
    check_eq("wr_no_strobe", wr_a, 8'h00);
    @(negedge clk);
    svld = 8'h10;
    #1 check_eq("wr_ready", ready_a, 1);
    @(negedge clk);
    svld = 8'h00; we = 1'b0;

    // Overlap: CRC (3) beats catch-all (7)
    req_a = 1'b1; addr = 16'h3291;
    #1 check_eq("ovl_sel", sel_a, 8'h08);
    @(negedge clk);
    req_a = 1'b0; svld = 8'h08;
    #1 check_eq("ovl_ready", ready_a, 1);
    check_eq("ovl_rdata", rdata_a, 8'hC3);
    @(negedge clk);
    svld = 8'h00;

    // Timeout on catch-all slave
    req_a = 1'b1; addr = 16'h4000;
    #1 check_eq("to_sel", sel_a, 8'h80);
    @(negedge clk);
    req_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 check_eq("to_wait_ready", ready_a, 0);
      @(negedge clk);
    end
    #1 check_eq("to_ready", ready_a, 1);
    check_eq("to_rdata", rdata_a, 8'hFF);
    check_eq("to_berr", berr_a, 1);
    check_eq("to_cause", cause_a, 2'b01);
    check_eq("to_eaddr", eaddr_a, 16'h4000);
    @(negedge clk);
    err_clear = 1'b1;
    #1 check_eq("to_idle_ready", ready_a, 0);
    @(negedge clk);
    err_clear = 1'b0;
    #1 check_eq("clr_berr", berr_a, 0);
    check_eq("clr_cause", cause_a, 0);
    check_eq("clr_eaddr", eaddr_a, 0);

    // Unmapped on fabric B
    req_b = 1'b1; addr = 16'h4000; we = 1'b1;
    #1 check_eq("um_sel", sel_b, 8'h00);
    check_eq("um_wr", wr_b, 8'h00);
    check_eq("um_ready_issue", ready_b, 0);
    @(negedge clk);
    req_b = 1'b0; we = 1'b0;
    #1 check_eq("um_ready", ready_b, 1);
    check_eq("um_rdata", rdata_b, 8'hFF);
    check_eq("um_berr", berr_b, 1);
    check_eq("um_cause", cause_b, 2'b10);
    check_eq("um_eaddr", eaddr_b, 16'h4000);

    // Second error (timeout) must not overwrite the first
    @(negedge clk);
    req_b = 1'b1; addr = 16'h0200;
    #1 check_eq("to2_sel", sel_b, 8'h01);
    @(negedge clk);
    req_b = 1'b0;
    repeat (4) @(negedge clk);
    #1 check_eq("to2_ready", ready_b, 1);
    check_eq("to2_cause_kept", cause_b, 2'b10);
    check_eq("to2_eaddr_kept", eaddr_b, 16'h4000);

    // Third error with a simultaneous clear: new error wins
    @(negedge clk);
    req_b = 1'b1; addr = 16'h1234;
    #1 check_eq("to3_sel", sel_b, 8'h02);
    @(negedge clk);
    req_b = 1'b0;
    repeat (3) @(negedge clk);
    err_clear = 1'b1;
    #1 check_eq("to3_pre_cause", cause_b, 2'b10);
    @(negedge clk);
    err_clear = 1'b0;
    #1 check_eq("to3_ready", ready_b, 1);
    check_eq("to3_berr", berr_b, 1);
    check_eq("to3_cause", cause_b, 2'b01);
    check_eq("to3_eaddr", eaddr_b, 16'h1234);
    @(negedge clk);

    // Reset in the middle of WAIT
    req_a = 1'b1; addr = 16'h0123;
    #1 check_eq("rw_sel", sel_a, 8'h01);
    @(negedge clk);
    req_a = 1'b0; reset = 1'b1; svld = 8'h01;
    #1 check_eq("rw_ready_in_reset", ready_a, 0);
    @(negedge clk);
    reset = 1'b0; svld = 8'h00;
    #1 check_eq("rw_idle_ready", ready_a, 0);
    check_eq("rw_idle_rdata", rdata_a, 8'h00);
    check_eq("rw_idle_sel", sel_a, 8'h00);
    check_eq("rw_berr_b", berr_b, 0);
    req_a = 1'b1; addr = 16'h1001;
    #1 check_eq("rw_fresh_sel", sel_a, 8'h02);
    @(negedge clk);
    req_a = 1'b0; svld = 8'h02;
    #1 check_eq("rw_fresh_ready", ready_a, 1);
    check_eq("rw_fresh_rdata", rdata_a, 8'h11);
    @(negedge clk);
    svld = 8'h00;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
